program_encoder: RTL and testbench
==================================

# program_encoder

Instruction-word encoder and instruction-memory loader for the single-cycle MIPS core. It accepts symbolic instruction requests (kind plus operand fields) over a valid/ready handshake and encodes them into 32-bit words using the same opcode/funct set the core's controller decodes. It writes the words sequentially into instruction memory and appends an NP terminator on finish. It holds the CPU in reset while loading and sits between the test/boot host and the instruction memory write port.

## Interface
- DEPTH, 64: instruction memory depth in words; power of two, ≥4
- AW, $clog2(DEPTH): address width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse: begin new program at address 0
- finish  in  1  pulse: append terminator, end load
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_kind  in  4  instruction kind (package enum)
- req_rs, req_rt, req_rd, req_shamt  in  5 each  register/shift fields
- req_imm  in  16  I-type immediate (raw bits, no extension)
- req_target  in  26  J-type target field
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  AW  word address
- imem_wdata  out  32  encoded word
- cpu_hold  out  1  high while not DONE/IDLE; drives CPU reset
- done  out  1  level, high in DONE
- err  out  1  sticky; cleared by reset or start
- count  out  AW+1  words written, terminator included

## Operation
- Kinds: ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, MUL=6, LW=7, SW=8, BEQ=9, BNE=10, ADDI=11, J=12, NP=13; 14–15 illegal.
- R-type (ADD..SLL): op 000000, funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, SLL 000000. SLL forces rs=0. Others force shamt=0.
- MUL: op 011100, rs|rt|rd, shamt 0, funct 000010.
- I-type: op|rs|rt|imm. LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000.
- J: 000010|target. NP: 111000, all other bits 0.
- States: IDLE, LOAD, TERM, DONE.
  - IDLE→LOAD on start.
  - LOAD→TERM on finish.
  - TERM→DONE after the terminator write cycle.
  - DONE→LOAD on start.
- start in any state: address, count and err cleared; next state is LOAD.
- req_ready = (state==LOAD) && !full && !finish; full when count==DEPTH.
- Illegal kind accepted: no write, err set, address unchanged.
- finish while full: no terminator, err set, go directly to DONE.
- finish and req_valid in the same cycle: finish wins; the request is not accepted.
- Address never wraps. Writes stop at DEPTH−1.

## Timing
- Reset values: state IDLE, imem_we 0, imem_addr 0, imem_wdata 0, count 0, done 0, err 0, cpu_hold 0, req_ready 0.
- Accept in cycle N → imem_we=1 with registered addr/data in cycle N+1. Address and count increment at the end of N+1.
- Throughput: one word per cycle.
- Terminator: finish in cycle N → NP write in N+1. done rises in N+2.
- cpu_hold is registered and high in LOAD and TERM. It drops in the same cycle done rises.
- Reset mid-load aborts without a further write. Memory contents written so far remain.

## Structure
- Package mips_encode_pkg holds:
  - kind enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_MUL, OP_NP)
  - funct constants
  - state enum
- Sub-module instr_word_encoder: purely combinational, inputs kind and fields, outputs word[31:0] and illegal. Reused by verification as the reference encoder.
- Top level holds the FSM, output registers, address and count counters.

## Test plan
- start, ADD rs=1 rt=2 rd=3 → cycle after accept: imem_we=1, addr=0, wdata=0x00221820; count=1.
- LW rs=29 rt=8 imm=4, then BEQ rs=4 rt=5 imm=0xFFFF back-to-back → 0x8FA80004 @1, 0x1085FFFF @2, on consecutive cycles.
- J target=0x10, finish → 0x08000010 then NP 0xE0000000 at the next address; done=1, cpu_hold=0 two cycles after finish.
- Kind 14 → no imem_we, err=1, next valid word written at the unchanged address; start clears err.
- Fill DEPTH words → req_ready=0; finish → no write, err=1, DONE; count=DEPTH.
- Assert reset mid-stream with req_valid high → no further imem_we, all outputs at reset values the next cycle; simultaneous finish+req_valid → request not accepted, terminator written.

Source files
------------

// File: rtl/mips_encode_pkg.sv
// Shared types and encoding constants for the MIPS instruction-memory loader.
package mips_encode_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned KIND_W = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;
  localparam int unsigned OP_W   = 6;

  typedef enum logic [KIND_W-1:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_SLL  = 4'd5,
    K_MUL  = 4'd6,
    K_LW   = 4'd7,
    K_SW   = 4'd8,
    K_BEQ  = 4'd9,
    K_BNE  = 4'd10,
    K_ADDI = 4'd11,
    K_J    = 4'd12,
    K_NP   = 4'd13
  } kind_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_MUL   = 6'b011100;
  localparam logic [OP_W-1:0] OP_NP    = 6'b111000;

  localparam logic [OP_W-1:0] F_ADD = 6'b100000;
  localparam logic [OP_W-1:0] F_SUB = 6'b100010;
  localparam logic [OP_W-1:0] F_AND = 6'b100100;
  localparam logic [OP_W-1:0] F_OR  = 6'b100101;
  localparam logic [OP_W-1:0] F_SLT = 6'b101010;
  localparam logic [OP_W-1:0] F_SLL = 6'b000000;
  localparam logic [OP_W-1:0] F_MUL = 6'b000010;

  localparam logic [WORD_W-1:0] NP_WORD = {OP_NP, 26'd0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_TERM,
    S_DONE
  } state_e;

  typedef struct packed {
    kind_e             kind;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  shamt;
    logic [IMM_W-1:0]  imm;
    logic [TGT_W-1:0]  target;
  } instr_req_t;

  // funct field of the three-register R-type ALU kinds
  function automatic logic [OP_W-1:0] rtype_funct(input kind_e k);
    case (k)
      K_SUB:   return F_SUB;
      K_AND:   return F_AND;
      K_OR:    return F_OR;
      K_SLT:   return F_SLT;
      default: return F_ADD;
    endcase
  endfunction

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational symbolic-request to 32-bit MIPS word encoder; flags illegal kinds.
import mips_encode_pkg::*;

module instr_word_encoder (
  input  instr_req_t         req,
  output logic [WORD_W-1:0]  word,
  output logic               illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (req.kind)
      K_ADD, K_SUB, K_AND, K_OR, K_SLT:
        word = {OP_RTYPE, req.rs, req.rt, req.rd, 5'd0, rtype_funct(req.kind)};
      K_SLL:  word = {OP_RTYPE, 5'd0, req.rt, req.rd, req.shamt, F_SLL};
      K_MUL:  word = {OP_MUL, req.rs, req.rt, req.rd, 5'd0, F_MUL};
      K_LW:   word = {OP_LW,   req.rs, req.rt, req.imm};
      K_SW:   word = {OP_SW,   req.rs, req.rt, req.imm};
      K_BEQ:  word = {OP_BEQ,  req.rs, req.rt, req.imm};
      K_BNE:  word = {OP_BNE,  req.rs, req.rt, req.imm};
      K_ADDI: word = {OP_ADDI, req.rs, req.rt, req.imm};
      K_J:    word = {OP_J, req.target};
      K_NP:   word = NP_WORD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_encoder.sv
// Loads encoded instruction words sequentially into imem, appends NP on finish,
// and holds the CPU in reset while loading.
import mips_encode_pkg::*;

module program_encoder #(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  output logic [AW-1:0]     imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [AW:0]       count
);

  localparam int unsigned CNT_W = AW + 1;

  state_e              state, state_d;
  instr_req_t          req;
  logic [WORD_W-1:0]   enc_word;
  logic                enc_illegal;
  logic                full;
  logic                accept;
  logic                we_d;
  logic [WORD_W-1:0]   wdata_d;
  logic                err_d;
  logic                clr;

  assign req = '{kind:   kind_e'(req_kind),
                 rs:     req_rs,
                 rt:     req_rt,
                 rd:     req_rd,
                 shamt:  req_shamt,
                 imm:    req_imm,
                 target: req_target};

  instr_word_encoder u_enc (
    .req     (req),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // Full also covers the last slot while its write is still in flight.
  assign full = (count == CNT_W'(DEPTH)) ||
                (imem_we && (count == CNT_W'(DEPTH - 1)));

  assign req_ready = (state == S_LOAD) && !full && !finish && !start;
  assign accept    = req_valid && req_ready;

  // Next-state and write decision
  always_comb begin
    state_d = state;
    we_d    = 1'b0;
    wdata_d = imem_wdata;
    err_d   = err;
    clr     = 1'b0;
    if (start) begin
      state_d = S_LOAD;
      err_d   = 1'b0;
      clr     = 1'b1;
    end else begin
      case (state)
        S_LOAD: begin
          if (finish) begin
            if (full) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              we_d    = 1'b1;
              wdata_d = NP_WORD;
              state_d = S_TERM;
            end
          end else if (accept) begin
            if (enc_illegal) begin
              err_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              wdata_d = enc_word;
            end
          end
        end
        S_TERM:  state_d = S_DONE;
        default: state_d = state;
      endcase
    end
  end

  // State, output registers and address/count counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_wdata <= '0;
      imem_addr  <= '0;
      count      <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
      cpu_hold   <= 1'b0;
    end else begin
      state      <= state_d;
      imem_we    <= we_d;
      imem_wdata <= wdata_d;
      err        <= err_d;
      done       <= (state_d == S_DONE);
      cpu_hold   <= (state_d == S_LOAD) || (state_d == S_TERM);
      if (clr) begin
        imem_addr <= '0;
        count     <= '0;
      end else if (imem_we) begin
        count <= count + CNT_W'(1);
        if (imem_addr != AW'(DEPTH - 1)) begin
          imem_addr <= imem_addr + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_program_encoder.sv
// Scoreboard bench for program_encoder: expected writes queued at accept, checked at imem_we.
module tb_program_encoder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic          clk = 1'b0;
  logic          reset, start, finish, req_valid;
  logic          req_ready;
  logic [3:0]    req_kind;
  logic [4:0]    req_rs, req_rt, req_rd, req_shamt;
  logic [15:0]   req_imm;
  logic [25:0]   req_target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold, done, err;
  logic [AW:0]   count;

  program_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_imm(req_imm), .req_target(req_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  exp_addr = 0;
  int  exp_count = 0;
  bit  exp_err  = 1'b0;

  function automatic logic [31:0] ref_word(input logic [3:0] k, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sh, input logic [15:0] imm,
                                           input logic [25:0] tgt);
    case (k)
      4'd0:  return {6'h00, rs, rt, rd, 5'h00, 6'h20};
      4'd1:  return {6'h00, rs, rt, rd, 5'h00, 6'h22};
      4'd2:  return {6'h00, rs, rt, rd, 5'h00, 6'h24};
      4'd3:  return {6'h00, rs, rt, rd, 5'h00, 6'h25};
      4'd4:  return {6'h00, rs, rt, rd, 5'h00, 6'h2A};
      4'd5:  return {6'h00, 5'h00, rt, rd, sh, 6'h00};
      4'd6:  return {6'h1C, rs, rt, rd, 5'h00, 6'h02};
      4'd7:  return {6'h23, rs, rt, imm};
      4'd8:  return {6'h2B, rs, rt, imm};
      4'd9:  return {6'h04, rs, rt, imm};
      4'd10: return {6'h05, rs, rt, imm};
      4'd11: return {6'h08, rs, rt, imm};
      4'd12: return {6'h02, tgt};
      4'd13: return 32'hE000_0000;
      default: return 32'h0;
    endcase
  endfunction

  // Write monitor: every imem_we must match the oldest queued expectation.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: addr=%0d data=%h, required no write", imem_addr, imem_wdata);
        end else begin
          e = sb.pop_front();
          if (imem_addr !== e.addr || imem_wdata !== e.data) begin
            failures++;
            $display("FAIL write_data: addr=%0d data=%h, required addr=%0d data=%h",
                     imem_addr, imem_wdata, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    sb.push_back({AW'(exp_addr), w});
    if (exp_addr < DEPTH - 1) exp_addr++;
    exp_count++;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_addr = 0; exp_count = 0; exp_err = 1'b0;
  endtask

  // Present one request and hold it until accepted; returns in the cycle after accept.
  task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt);
    bit got = 1'b0;
    int n = 0;
    req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh;
    req_imm = imm; req_target = tgt; req_valid = 1'b1;
    while (!got && n < 20) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        got = 1'b1;
        if (k <= 4'd13) push_word(ref_word(k, rs, rt, rd, sh, imm, tgt));
        else exp_err = 1'b1;
      end
      step();
      n++;
    end
    req_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL send_timeout: kind=%0d not accepted, required accept within 20 cycles", k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; finish = 1'b0; req_valid = 1'b0;
    req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_shamt = '0;
    req_imm = '0; req_target = '0;
    step(); step();
    checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b, required 0", imem_we); end
    checks++; if (imem_addr !== '0) begin failures++; $display("FAIL reset_addr: got %0d, required 0", imem_addr); end
    checks++; if (imem_wdata !== '0) begin failures++; $display("FAIL reset_wdata: got %h, required 0", imem_wdata); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count: got %0d, required 0", count); end
    checks++; if ({done, err, cpu_hold, req_ready} !== 4'b0) begin failures++; $display("FAIL reset_flags: got %b, required 0000", {done, err, cpu_hold, req_ready}); end
    reset = 1'b0;
    step();
    checks++; if ({cpu_hold, req_ready} !== 2'b00) begin failures++; $display("FAIL idle_flags: got %b, required 00", {cpu_hold, req_ready}); end
  endtask

  task automatic test_add();
    do_start();
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL load_hold: got %b, required 1", cpu_hold); end
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 32'h0022_1820) begin
      failures++; $display("FAIL add_write: we=%b addr=%0d data=%h, required 1 0 00221820", imem_we, imem_addr, imem_wdata); end
    step();
    checks++; if (count !== 7'd1) begin failures++; $display("FAIL add_count: got %0d, required 1", count); end
  endtask

  task automatic test_back_to_back();
    send(4'd7, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 6'd1 || imem_wdata !== 32'h8FA8_0004) begin
      failures++; $display("FAIL lw_write: we=%b addr=%0d data=%h, required 1 1 8fa80004", imem_we, imem_addr, imem_wdata); end
    send(4'd9, 5'd4, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'h0);
    checks++; if (imem_we !== 1'b1 || imem_addr !== 6'd2 || imem_wdata !== 32'h1085_FFFF) begin
      failures++; $display("FAIL beq_write: we=%b addr=%0d data=%h, required 1 2 1085ffff", imem_we, imem_addr, imem_wdata); end
    step();
    checks++; if (count !== 7'(exp_count)) begin failures++; $display("FAIL b2b_count: got %0d, required %0d", count, exp_count); end
  endtask

  task automatic test_jump_finish();
    send(4'd12, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    checks++; if (imem_wdata !== 32'h0800_0010) begin failures++; $display("FAIL j_write: got %h, required 08000010", imem_wdata); end
    finish = 1'b1;
    @(negedge clk);
    push_word(32'hE000_0000);
    step();
    finish = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 6'd4 || imem_wdata !== 32'hE000_0000) begin
      failures++; $display("FAIL np_write: we=%b addr=%0d data=%h, required 1 4 e0000000", imem_we, imem_addr, imem_wdata); end
    checks++; if ({done, cpu_hold} !== 2'b01) begin failures++; $display("FAIL term_flags: done,hold=%b, required 01", {done, cpu_hold}); end
    step();
    checks++; if ({done, cpu_hold} !== 2'b10) begin failures++; $display("FAIL done_flags: done,hold=%b, required 10", {done, cpu_hold}); end
    checks++; if (count !== 7'd5) begin failures++; $display("FAIL term_count: got %0d, required 5", count); end
  endtask

  task automatic test_illegal();
    do_start();
    send(4'd14, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    checks++; if (imem_we !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL illegal: we=%b err=%b, required 0 1", imem_we, err); end
    send(4'd11, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0);
    checks++; if (imem_addr !== 6'd0 || imem_wdata !== 32'h2001_1234) begin
      failures++; $display("FAIL after_illegal: addr=%0d data=%h, required 0 20011234", imem_addr, imem_wdata); end
    step();
    do_start();
    checks++; if (err !== 1'b0 || count !== 7'd0) begin failures++; $display("FAIL start_clears: err=%b count=%0d, required 0 0", err, count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      send(4'(i % 14), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom));
    end
    req_kind = 4'd0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %b, required 0", req_ready); end
      step();
    end
    req_valid = 1'b0;
    checks++; if (count !== 7'(DEPTH) || imem_addr !== 6'(DEPTH - 1)) begin
      failures++; $display("FAIL full_count: count=%0d addr=%0d, required %0d %0d", count, imem_addr, DEPTH, DEPTH - 1); end
    finish = 1'b1;
    step();
    finish = 1'b0;
    checks++; if ({imem_we, err, done, cpu_hold} !== 4'b0110) begin
      failures++; $display("FAIL full_finish: we,err,done,hold=%b, required 0110", {imem_we, err, done, cpu_hold}); end
    checks++; if (count !== 7'(DEPTH)) begin failures++; $display("FAIL full_final_count: got %0d, required %0d", count, DEPTH); end
  endtask

  task automatic test_reset_mid();
    do_start();
    req_kind = 4'd0; req_rs = 5'd7; req_rt = 5'd8; req_rd = 5'd9; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL stream_ready: got %b, required 1", req_ready); end
      else push_word(ref_word(4'd0, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0));
      step();
    end
    reset = 1'b1;
    step();
    exp_addr = 0; exp_count = 0; exp_err = 1'b0;
    checks++; if ({imem_we, done, err, cpu_hold, req_ready} !== 5'b0) begin
      failures++; $display("FAIL midreset_flags: got %b, required 00000", {imem_we, done, err, cpu_hold, req_ready}); end
    checks++; if (imem_addr !== '0 || imem_wdata !== '0 || count !== '0) begin
      failures++; $display("FAIL midreset_regs: addr=%0d data=%h count=%0d, required 0", imem_addr, imem_wdata, count); end
    step();
    reset = 1'b0; req_valid = 1'b0;
    step();
  endtask

  task automatic test_finish_with_valid();
    do_start();
    send(4'd8, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0008, 26'h0);
    checks++; if (imem_wdata !== 32'hAC43_0008) begin failures++; $display("FAIL sw_write: got %h, required ac430008", imem_wdata); end
    finish = 1'b1; req_valid = 1'b1; req_kind = 4'd3;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL finish_ready: got %b, required 0", req_ready); end
    push_word(32'hE000_0000);
    step();
    finish = 1'b0; req_valid = 1'b0;
    checks++; if (imem_we !== 1'b1 || imem_addr !== 6'd1 || imem_wdata !== 32'hE000_0000) begin
      failures++; $display("FAIL fv_term: we=%b addr=%0d data=%h, required 1 1 e0000000", imem_we, imem_addr, imem_wdata); end
    step();
    checks++; if (done !== 1'b1 || count !== 7'(exp_count)) begin
      failures++; $display("FAIL fv_done: done=%b count=%0d, required 1 %0d", done, count, exp_count); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_jump_finish();
    test_illegal();
    test_fill();
    test_reset_mid();
    test_finish_with_valid();
    step(); step(); step();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain: %0d writes outstanding, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
